// File: rtl/net_rx_pkg.sv
// Shared types and constants for the UDP receive packet buffer.
package net_rx_pkg;

    localparam int UDP_PORT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DROP,
        NOMATCH
    } rx_state_t;

    // Channel id width: a single channel still needs one bit.
    function automatic int ch_id_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/udp_rx_packet_buffer_if.sv
// Chunk input stream and committed word output stream of the receive buffer.
// master: upstream transport plus the word consumer; slave: the buffer.
interface udp_rx_packet_buffer_if
    import net_rx_pkg::*;
#(
    parameter int N         = 2,
    parameter int DATA_SIZE = 16,
    parameter int NUM_CH    = 4
);
    localparam int CH_W = ch_id_width(NUM_CH);

    logic [N-1:0]          axiid;
    logic                  axiiv;
    logic [UDP_PORT_W-1:0] dst_port_in;
    logic                  frame_done;
    logic                  frame_kill;

    logic                  axiov;
    logic [DATA_SIZE-1:0]  axiod;
    logic [CH_W-1:0]       axio_ch;
    logic                  axio_last;
    logic                  axior;

    modport master (
        output axiid, axiiv, dst_port_in, frame_done, frame_kill, axior,
        input  axiov, axiod, axio_ch, axio_last
    );

    modport slave (
        input  axiid, axiiv, dst_port_in, frame_done, frame_kill, axior,
        output axiov, axiod, axio_ch, axio_last
    );

endinterface

// File: rtl/rx_word_packer.sv
// Shifts N-bit chunks into a DATA_SIZE-bit word, first chunk ending in the MSBs.
// word/word_valid present the completed word in the cycle its final chunk arrives;
// partial_word is the incomplete word left-aligned with zero padding in the LSBs.
module rx_word_packer #(
    parameter int N         = 2,
    parameter int DATA_SIZE = 16
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         chunk,
    input  logic                 valid,
    input  logic                 clear,
    output logic [DATA_SIZE-1:0] word,
    output logic                 word_valid,
    output logic                 partial_nonempty,
    output logic [DATA_SIZE-1:0] partial_word
);
    localparam int CPW   = DATA_SIZE / N;
    localparam int CNT_W = (CPW > 1) ? $clog2(CPW) : 1;

    logic [DATA_SIZE-1:0] shreg;
    logic [CNT_W-1:0]     cnt;

    assign word             = (shreg << N) | DATA_SIZE'(chunk);
    assign word_valid       = valid && (cnt == CNT_W'(CPW - 1));
    assign partial_nonempty = (cnt != '0);
    assign partial_word     = shreg << (N * (CPW - int'(cnt)));

    // Accumulate chunks; a completed word or a clear empties the packer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (clear || word_valid) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (valid) begin
            shreg <= word;
            cnt   <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/udp_rx_packet_buffer.sv
// Packs UDP payload chunks into words, steers each frame to a channel by
// destination port and buffers it speculatively; only committed frames are
// visible on the output stream.
module udp_rx_packet_buffer
    import net_rx_pkg::*;
#(
    parameter int N         = 2,
    parameter int DATA_SIZE = 16,
    parameter int NUM_CH    = 4,
    parameter int DEPTH     = 64
)(
    input  logic                         clk,
    input  logic                         rst_n,
    udp_rx_packet_buffer_if.slave        bus,
    input  logic [UDP_PORT_W*NUM_CH-1:0] ch_ports,
    input  logic [NUM_CH-1:0]            ch_enable,
    output logic [15:0]                  drop_count,
    output logic [15:0]                  nomatch_count
);
    localparam int CH_W = ch_id_width(NUM_CH);
    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = AW + 1;

    typedef struct packed {
        logic                 last;
        logic [CH_W-1:0]      ch;
        logic [DATA_SIZE-1:0] data;
    } rx_entry_t;

    rx_state_t state, state_next;

    logic [PW-1:0] rd_ptr, rd_ptr_next, wr_ptr, commit_ptr;
    logic [AW-1:0] last_addr;
    logic [CH_W-1:0] frame_ch, match_ch;
    logic match;

    logic [DATA_SIZE-1:0] data_mem [DEPTH];
    logic [CH_W-1:0]      ch_mem   [DEPTH];
    logic [DEPTH-1:0]     last_arr;

    logic chunk_ok, read_fire, out_valid, full;
    logic pk_valid, pk_clear, pk_word_valid, pk_nonempty;
    logic [DATA_SIZE-1:0] pk_word, pk_partial;

    logic wr_en, set_last, commit, rollback, drop_inc, nomatch_inc, cap_ch;
    rx_entry_t wr_entry, rd_entry;

    // A chunk coinciding with an end-of-frame event is discarded.
    assign chunk_ok    = bus.axiiv && !bus.frame_done && !bus.frame_kill;
    assign pk_valid    = chunk_ok && ((state == IDLE && match) || state == RECV);
    assign out_valid   = (commit_ptr != rd_ptr);
    assign read_fire   = out_valid && bus.axior;
    assign rd_ptr_next = rd_ptr + PW'(read_fire);
    assign full        = ((wr_ptr - rd_ptr_next) == PW'(DEPTH));

    rx_word_packer #(
        .N         (N),
        .DATA_SIZE (DATA_SIZE)
    ) u_packer (
        .clk              (clk),
        .rst_n            (rst_n),
        .chunk            (bus.axiid),
        .valid            (pk_valid),
        .clear            (pk_clear),
        .word             (pk_word),
        .word_valid       (pk_word_valid),
        .partial_nonempty (pk_nonempty),
        .partial_word     (pk_partial)
    );

    // Port lookup: the lowest enabled channel whose port matches wins.
    always_comb begin
        match    = 1'b0;
        match_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_enable[i] && ch_ports[UDP_PORT_W*i +: UDP_PORT_W] == bus.dst_port_in) begin
                match    = 1'b1;
                match_ch = CH_W'(i);
            end
        end
    end

    // Frame state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next state plus FIFO write, commit and rollback decisions.
    always_comb begin
        state_next  = state;
        pk_clear    = 1'b0;
        wr_en       = 1'b0;
        wr_entry    = '0;
        set_last    = 1'b0;
        commit      = 1'b0;
        rollback    = 1'b0;
        drop_inc    = 1'b0;
        nomatch_inc = 1'b0;
        cap_ch      = 1'b0;
        case (state)
            IDLE: begin
                if (chunk_ok) begin
                    if (match) begin
                        cap_ch     = 1'b1;
                        state_next = RECV;
                        if (pk_word_valid) begin
                            if (full) begin
                                pk_clear   = 1'b1;
                                rollback   = 1'b1;
                                state_next = DROP;
                            end else begin
                                wr_en    = 1'b1;
                                wr_entry = '{last: 1'b0, ch: match_ch, data: pk_word};
                            end
                        end
                    end else begin
                        state_next = NOMATCH;
                    end
                end
            end
            RECV: begin
                if (bus.frame_kill) begin
                    pk_clear   = 1'b1;
                    rollback   = 1'b1;
                    drop_inc   = 1'b1;
                    state_next = IDLE;
                end else if (bus.frame_done) begin
                    pk_clear   = 1'b1;
                    state_next = IDLE;
                    if (pk_nonempty) begin
                        if (full) begin
                            rollback = 1'b1;
                            drop_inc = 1'b1;
                        end else begin
                            wr_en    = 1'b1;
                            wr_entry = '{last: 1'b1, ch: frame_ch, data: pk_partial};
                            commit   = 1'b1;
                        end
                    end else begin
                        set_last = 1'b1;
                        commit   = 1'b1;
                    end
                end else if (pk_valid && pk_word_valid) begin
                    if (full) begin
                        pk_clear   = 1'b1;
                        rollback   = 1'b1;
                        state_next = DROP;
                    end else begin
                        wr_en    = 1'b1;
                        wr_entry = '{last: 1'b0, ch: frame_ch, data: pk_word};
                    end
                end
            end
            DROP: begin
                if (bus.frame_done || bus.frame_kill) begin
                    drop_inc   = 1'b1;
                    state_next = IDLE;
                end
            end
            NOMATCH: begin
                if (bus.frame_done || bus.frame_kill) begin
                    nomatch_inc = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Read, speculative write and commit pointers plus per-frame bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            last_addr  <= '0;
            frame_ch   <= '0;
        end else begin
            rd_ptr <= rd_ptr_next;
            if (rollback)   wr_ptr <= commit_ptr;
            else if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (commit)     commit_ptr <= wr_en ? wr_ptr + PW'(1) : wr_ptr;
            if (wr_en)      last_addr <= wr_ptr[AW-1:0];
            if (cap_ch)     frame_ch <= match_ch;
        end
    end

    // Entry storage; the last array is re-marked when a frame ends on a full word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_ptr[AW-1:0]] <= wr_entry.data;
            ch_mem[wr_ptr[AW-1:0]]   <= wr_entry.ch;
            last_arr[wr_ptr[AW-1:0]] <= wr_entry.last;
        end
        if (set_last) last_arr[last_addr] <= 1'b1;
    end

    // Saturating drop and no-match frame counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count    <= '0;
            nomatch_count <= '0;
        end else begin
            if (drop_inc && drop_count != 16'hFFFF)       drop_count    <= drop_count + 16'd1;
            if (nomatch_inc && nomatch_count != 16'hFFFF) nomatch_count <= nomatch_count + 16'd1;
        end
    end

    assign rd_entry = '{last: last_arr[rd_ptr[AW-1:0]],
                        ch:   ch_mem[rd_ptr[AW-1:0]],
                        data: data_mem[rd_ptr[AW-1:0]]};

    assign bus.axiov     = out_valid;
    assign bus.axiod     = out_valid ? rd_entry.data : '0;
    assign bus.axio_ch   = out_valid ? rd_entry.ch   : '0;
    assign bus.axio_last = out_valid ? rd_entry.last : 1'b0;

endmodule
